fp_pack_round: RTL and testbench



---
 rtl/fp_pack_round.sv | 136 +++++++++++++
 tb/tb_fp_pack_round.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/fp_pack_round.sv
// Normalize / round-to-nearest-even / pack stage for the binary32 FPU datapath.
// Normalizes one bit per cycle, then rounds and packs with a 4-bit status word.
module fp_pack_round (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        sign_in,
  input  logic [9:0]  exp_in,
  input  logic [47:0] mant_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] data_out,
  output logic [3:0]  status_out
);

  typedef enum logic [1:0] {IDLE, NORM, ROUND} state_t;

  localparam logic [3:0] ST_ZERO  = 4'b1000;
  localparam logic [3:0] ST_OVF   = 4'b0101;
  localparam logic [3:0] ST_UNF   = 4'b0011;
  localparam logic [3:0] ST_EXACT = 4'b1000;
  localparam logic [3:0] ST_INEX  = 4'b0001;

  state_t             state_q, state_d;
  logic               sign_q, sign_d;
  logic signed [10:0] exp_q, exp_d;
  logic [47:0]        mant_q, mant_d;
  logic               sticky_q, sticky_d;
  logic               done_q, done_d;
  logic [31:0]        data_q, data_d;
  logic [3:0]         status_q, status_d;

  // Rounding fields, only meaningful in ROUND.
  logic               guard, sticky_all, lsb, round_up;
  logic [23:0]        frac_rnd;
  logic signed [10:0] exp_rnd;

  assign guard      = mant_q[22];
  assign sticky_all = (|mant_q[21:0]) | sticky_q;
  assign lsb        = mant_q[23];
  assign round_up   = guard & (sticky_all | lsb);
  assign frac_rnd   = {1'b0, mant_q[45:23]} + {23'b0, round_up};
  // A carry out of the fraction leaves frac_rnd[22:0] = 0 and bumps the exponent.
  assign exp_rnd    = exp_q + $signed({10'b0, frac_rnd[23]});

  // NOTE: every variable assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    mant_d   = mant_q;
    sticky_d = sticky_q;
    done_d   = 1'b0;
    data_d   = data_q;
    status_d = status_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          sign_d   = sign_in;
          exp_d    = {exp_in[9], exp_in};
          mant_d   = mant_in;
          sticky_d = 1'b0;
          state_d  = NORM;
        end
      end

      NORM: begin
        if (mant_q[47]) begin
          mant_d   = mant_q >> 1;
          sticky_d = sticky_q | mant_q[0];
          exp_d    = exp_q + 11'sd1;
        end else if ((mant_q != 48'h0) && !mant_q[46] && (exp_q > 11'sd0)) begin
          mant_d = mant_q << 1;
          exp_d  = exp_q - 11'sd1;
        end else begin
          state_d = ROUND;
        end
      end

      ROUND: begin
        done_d  = 1'b1;
        state_d = IDLE;
        if (mant_q == 48'h0) begin
          data_d   = {sign_q, 31'b0};
          status_d = ST_ZERO;
        end else if (exp_rnd >= 11'sd255) begin
          data_d   = {sign_q, 8'hFF, 23'b0};
          status_d = ST_OVF;
        end else if (exp_rnd <= 11'sd0) begin
          // Denormals flush to zero, matching the operand-unpack policy.
          data_d   = {sign_q, 31'b0};
          status_d = ST_UNF;
        end else begin
          data_d   = {sign_q, exp_rnd[7:0], frac_rnd[22:0]};
          status_d = (guard | sticky_all) ? ST_INEX : ST_EXACT;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: datapath registers are reset too, so an aborted operation
      // leaves no stale mantissa/exponent behind.
      state_q  <= IDLE;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      mant_q   <= '0;
      sticky_q <= 1'b0;
      done_q   <= 1'b0;
      data_q   <= '0;
      status_q <= '0;
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      mant_q   <= mant_d;
      sticky_q <= sticky_d;
      done_q   <= done_d;
      data_q   <= data_d;
      status_q <= status_d;
    end
  end

  assign busy       = (state_q == NORM) || (state_q == ROUND);
  assign done       = done_q;
  assign data_out   = data_q;
  assign status_out = status_q;

endmodule

// File: tb/tb_fp_pack_round.sv
// Self-checking bench for fp_pack_round: hand-derived expectations are queued
// at start and compared (data, status, completion cycle) when done pulses.
module tb_fp_pack_round;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        sign_in;
  logic [9:0]  exp_in;
  logic [47:0] mant_in;
  logic        busy;
  logic        done;
  logic [31:0] data_out;
  logic [3:0]  status_out;

  fp_pack_round dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .sign_in    (sign_in),
    .exp_in     (exp_in),
    .mant_in    (mant_in),
    .busy       (busy),
    .done       (done),
    .data_out   (data_out),
    .status_out (status_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  status;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   cyc        = 0;
  int   checks     = 0;
  int   failures   = 0;
  int   done_count = 0;
  int   pushed     = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard side: compare every done against the oldest expectation.
  always @(negedge clk) begin
    if (done) begin
      done_count++;
      if (sb.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("data_out", 64'(data_out), 64'(e.data));
        check("status_out", 64'(status_out), 64'(e.status));
        check("done_cycle", 64'(cyc), 64'(e.due));
      end
    end
  end

  // Called just after a negedge; start is seen by the next rising edge.
  task automatic send(input logic s, input logic [9:0] e, input logic [47:0] m,
                      input logic [31:0] d, input logic [3:0] st, input int k);
    exp_t x;
    x.data   = d;
    x.status = st;
    x.due    = cyc + 1 + 2 + k;
    sb.push_back(x);
    pushed++;
    sign_in = s;
    exp_in  = e;
    mant_in = m;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("idle_timeout", 64'd1, 64'd0);
    @(negedge clk);
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    sign_in = 1'b0;
    exp_in  = '0;
    mant_in = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_data", 64'(data_out), 64'd0);
    check("rst_status", 64'(status_out), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Exact normal, with busy profile across the operation.
    send(1'b0, 10'd127, 48'h4000_0000_0000, 32'h3F80_0000, 4'b1000, 0);
    check("busy_c1", 64'(busy), 64'd1);
    @(negedge clk);
    check("busy_c2", 64'(busy), 64'd1);
    @(negedge clk);
    check("busy_done_cycle", 64'(busy), 64'd0);
    check("done_pulse", 64'(done), 64'd1);
    @(negedge clk);
    check("done_one_cycle", 64'(done), 64'd0);

    send(1'b0, 10'd127, 48'h8000_0000_0000, 32'h4000_0000, 4'b1000, 1); wait_idle();
    send(1'b0, 10'd127, 48'h4000_0040_0000, 32'h3F80_0000, 4'b0001, 0); wait_idle();
    send(1'b0, 10'd127, 48'h4000_00C0_0000, 32'h3F80_0002, 4'b0001, 0); wait_idle();
    send(1'b1, 10'd254, 48'hFFFF_FFFF_FFFF, 32'hFF80_0000, 4'b0101, 1); wait_idle();
    send(1'b0, 10'd1,   48'h0000_0000_0001, 32'h0000_0000, 4'b0011, 1); wait_idle();
    send(1'b1, 10'd127, 48'h0,              32'h8000_0000, 4'b1000, 0); wait_idle();
    // Right shift drops a 1 into sticky, forcing the tie to round up.
    send(1'b0, 10'd127, 48'h8000_0080_0001, 32'h4000_0001, 4'b0001, 1); wait_idle();
    send(1'b0, 10'd255, 48'h4000_0000_0000, 32'h7F80_0000, 4'b0101, 0); wait_idle();
    send(1'b0, 10'd0,   48'h4000_0000_0000, 32'h0000_0000, 4'b0011, 0); wait_idle();
    send(1'b0, 10'd254, 48'h7FFF_FF80_0000, 32'h7F7F_FFFF, 4'b1000, 0); wait_idle();
    // Longest normalization: 46 left shifts, exponent 127 -> 81.
    send(1'b0, 10'd127, 48'h0000_0000_0001, 32'h2880_0000, 4'b1000, 46);

    // A second start while busy must be ignored.
    repeat (5) @(negedge clk);
    sign_in = 1'b1; exp_in = 10'd127; mant_in = 48'h4000_0000_0000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (10) @(negedge clk);
    check("done_count_busy_start", 64'(done_count), 64'(pushed));

    // Back-to-back: start issued during the done cycle.
    send(1'b0, 10'd127, 48'h4000_0000_0000, 32'h3F80_0000, 4'b1000, 0);
    begin
      int n = 0;
      while (!done && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (n >= 20) check("b2b_timeout", 64'd1, 64'd0);
    end
    send(1'b1, 10'd127, 48'h8000_0000_0000, 32'hC000_0000, 4'b1000, 1);
    wait_idle();

    // Reset in the middle of NORM aborts with no done.
    sign_in = 1'b0; exp_in = 10'd127; mant_in = 48'h0000_0000_0001; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_abort_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_data", 64'(data_out), 64'd0);
    check("abort_status", 64'(status_out), 64'd0);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    check("done_count_final", 64'(done_count), 64'(pushed));
    check("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
